sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_if.sv | 44 ++++
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and serial-SRAM-encoder-side signals of sram_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sram_port_arbiter_if #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
);

  logic                     p0_req;
  logic                     p1_req;
  logic [ADDRESS_WIDTH-1:0] p0_addr;
  logic [ADDRESS_WIDTH-1:0] p1_addr;
  logic                     p0_we;
  logic                     p1_we;
  logic [WORD_WIDTH-1:0]    p0_wdata;
  logic [WORD_WIDTH-1:0]    p1_wdata;
  logic                     p0_ack;
  logic                     p1_ack;
  logic [WORD_WIDTH-1:0]    p0_rdata;
  logic [WORD_WIDTH-1:0]    p1_rdata;
  logic                     mem_initialized;
  logic                     mem_busy;
  logic                     mem_request;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_write_enable;
  logic [WORD_WIDTH-1:0]    mem_data_out;
  logic [WORD_WIDTH-1:0]    mem_data_in;
  logic                     grant;
  logic                     active;

  modport slave (
    input  p0_req, p1_req, p0_addr, p1_addr, p0_we, p1_we, p0_wdata, p1_wdata,
    input  mem_initialized, mem_busy, mem_data_in,
    output p0_ack, p1_ack, p0_rdata, p1_rdata,
    output mem_request, mem_address, mem_write_enable, mem_data_out, grant, active
  );

  modport master (
    output p0_req, p1_req, p0_addr, p1_addr, p0_we, p1_we, p0_wdata, p1_wdata,
    output mem_initialized, mem_busy, mem_data_in,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata,
    input  mem_request, mem_address, mem_write_enable, mem_data_out, grant, active
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a serial SRAM encoder.
// One transfer at a time through IDLE -> REQ -> BUSY -> DONE; all outputs registered.
module sram_port_arbiter #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     mem_request_q, mem_request_d;
  logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                     mem_write_enable_q, mem_write_enable_d;
  logic [WORD_WIDTH-1:0]    mem_data_out_q, mem_data_out_d;
  logic                     grant_q, grant_d;
  logic                     active_q, active_d;
  logic                     p0_ack_q, p0_ack_d;
  logic                     p1_ack_q, p1_ack_d;
  logic [WORD_WIDTH-1:0]    p0_rdata_q, p0_rdata_d;
  logic [WORD_WIDTH-1:0]    p1_rdata_q, p1_rdata_d;
  logic                     sel;

  // Under contention the requester not granted last wins.
  always_comb begin
    if (bus.p0_req && bus.p1_req) begin
      sel = ~grant_q;
    end else if (bus.p1_req) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d            = state_q;
    mem_request_d      = mem_request_q;
    mem_address_d      = mem_address_q;
    mem_write_enable_d = mem_write_enable_q;
    mem_data_out_d     = mem_data_out_q;
    grant_d            = grant_q;
    p0_rdata_d         = p0_rdata_q;
    p1_rdata_d         = p1_rdata_q;
    p0_ack_d           = 1'b0;
    p1_ack_d           = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_initialized && (bus.p0_req || bus.p1_req)) begin
          grant_d            = sel;
          mem_address_d      = sel ? bus.p1_addr  : bus.p0_addr;
          mem_write_enable_d = sel ? bus.p1_we    : bus.p0_we;
          mem_data_out_d     = sel ? bus.p1_wdata : bus.p0_wdata;
          mem_request_d      = 1'b1;
          state_d            = REQ;
        end else begin
          mem_request_d = 1'b0;
        end
      end
      // The encoder samples requests only on alternate cycles: hold until it reports busy.
      REQ: begin
        if (bus.mem_busy) begin
          mem_request_d = 1'b0;
          state_d       = BUSY;
        end else begin
          mem_request_d = 1'b1;
        end
      end
      BUSY: begin
        if (!bus.mem_busy) begin
          if (grant_q) begin
            p1_rdata_d = bus.mem_data_in;
            p1_ack_d   = 1'b1;
          end else begin
            p0_rdata_d = bus.mem_data_in;
            p0_ack_d   = 1'b1;
          end
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d       = IDLE;
        mem_request_d = 1'b0;
      end
    endcase
    active_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      mem_request_q      <= 1'b0;
      mem_address_q      <= '0;
      mem_write_enable_q <= 1'b0;
      mem_data_out_q     <= '0;
      grant_q            <= 1'b1;
      active_q           <= 1'b0;
      p0_ack_q           <= 1'b0;
      p1_ack_q           <= 1'b0;
      p0_rdata_q         <= '0;
      p1_rdata_q         <= '0;
    end else begin
      state_q            <= state_d;
      mem_request_q      <= mem_request_d;
      mem_address_q      <= mem_address_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_data_out_q     <= mem_data_out_d;
      grant_q            <= grant_d;
      active_q           <= active_d;
      p0_ack_q           <= p0_ack_d;
      p1_ack_q           <= p1_ack_d;
      p0_rdata_q         <= p0_rdata_d;
      p1_rdata_q         <= p1_rdata_d;
    end
  end

  assign bus.mem_request      = mem_request_q;
  assign bus.mem_address      = mem_address_q;
  assign bus.mem_write_enable = mem_write_enable_q;
  assign bus.mem_data_out     = mem_data_out_q;
  assign bus.grant            = grant_q;
  assign bus.active           = active_q;
  assign bus.p0_ack           = p0_ack_q;
  assign bus.p1_ack           = p1_ack_q;
  assign bus.p0_rdata         = p0_rdata_q;
  assign bus.p1_rdata         = p1_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model (who wins, what is latched, what comes back).
module tb_sram_port_arbiter;

  localparam int WW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

  sram_port_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int both_ack_cnt = 0;
  int req_outside_cnt = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;

  // Transaction-level model: last winner and the word each requester should hold.
  logic          last_grant;
  logic [WW-1:0] exp_rdata [2];

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.p0_ack && bus.p1_ack) both_ack_cnt++;
      if (bus.mem_request && !bus.active) req_outside_cnt++;
      if (bus.p0_ack) ack_cnt0++;
      if (bus.p1_ack) ack_cnt1++;
    end
  end

  function automatic logic expected_winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    else return r1;
  endfunction

  task automatic model_reset();
    last_grant   = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic set_cmd(input logic n, input logic [AW-1:0] a, input logic we, input logic [WW-1:0] d);
    if (n) begin
      bus.p1_addr = a; bus.p1_we = we; bus.p1_wdata = d; bus.p1_req = 1'b1;
    end else begin
      bus.p0_addr = a; bus.p0_we = we; bus.p0_wdata = d; bus.p0_req = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Encoder model: called at the negedge where mem_request is first seen high.
  // Raises busy after d1 cycles, holds it d2 cycles, then drops it with the return word.
  task automatic serve(input int d1, input int d2, input logic [WW-1:0] word,
                       input logic [AW-1:0] ea, input logic ew, input logic [WW-1:0] ed,
                       output int bad_req, output int bad_hold);
    bad_req  = 0;
    bad_hold = 0;
    for (int i = 0; i < d1; i++) begin
      @(negedge clk);
      if (bus.mem_request !== 1'b1) bad_req++;
      if ({bus.mem_address, bus.mem_write_enable, bus.mem_data_out} !== {ea, ew, ed}) bad_hold++;
    end
    bus.mem_busy    = 1'b1;
    bus.mem_data_in = ~word;
    for (int i = 0; i < d2; i++) begin
      @(negedge clk);
      if (bus.mem_request !== 1'b0) bad_req++;
      if ({bus.mem_address, bus.mem_write_enable, bus.mem_data_out} !== {ea, ew, ed}) bad_hold++;
    end
    bus.mem_busy    = 1'b0;
    bus.mem_data_in = word;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.mem_request, bus.active, bus.p0_ack, bus.p1_ack, bus.mem_write_enable, bus.grant} !== 6'b000001) begin
      errors++; $display("FAIL reset_flags: got %b want 000001",
        {bus.mem_request, bus.active, bus.p0_ack, bus.p1_ack, bus.mem_write_enable, bus.grant});
    end
    checks++;
    if ({bus.p0_rdata, bus.p1_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", {bus.p0_rdata, bus.p1_rdata});
    end
    checks++;
    if ({bus.mem_address, bus.mem_data_out} !== 32'h0) begin
      errors++; $display("FAIL reset_cmd: got %h want 0", {bus.mem_address, bus.mem_data_out});
    end
    reset  = 1'b0;
    model_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_uninit_read();
    int n_bad, br, bh;
    set_cmd(1'b0, 16'h1234, 1'b0, 16'h5555);
    n_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_request !== 1'b0 || bus.active !== 1'b0) n_bad++;
    end
    checks++;
    if (n_bad !== 0) begin errors++; $display("FAIL uninit_idle: got %0d bad cycles want 0", n_bad); end
    bus.mem_initialized = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_request, bus.grant, bus.active} !== 3'b101) begin
      errors++; $display("FAIL init_latency: got %b want 101", {bus.mem_request, bus.grant, bus.active});
    end
    checks++;
    if ({bus.mem_address, bus.mem_write_enable} !== {16'h1234, 1'b0}) begin
      errors++; $display("FAIL read_cmd: got %h/%b want 1234/0", bus.mem_address, bus.mem_write_enable);
    end
    last_grant = 1'b0;
    serve(2, 12, 16'hBEEF, 16'h1234, 1'b0, 16'h5555, br, bh);
    checks++;
    if (br + bh !== 0) begin errors++; $display("FAIL read_protocol: got req %0d hold %0d want 0 0", br, bh); end
    @(negedge clk);
    checks++;
    if ({bus.p1_ack, bus.p0_ack} !== 2'b01) begin
      errors++; $display("FAIL read_ack: got %b want 01", {bus.p1_ack, bus.p0_ack});
    end
    exp_rdata[0] = 16'hBEEF;
    checks++;
    if ({bus.p0_rdata, bus.p1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
      errors++; $display("FAIL read_rdata: got %h/%h want beef/0", bus.p0_rdata, bus.p1_rdata);
    end
    bus.p0_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({ack_cnt0, ack_cnt1, 31'b0, bus.active} !== {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("FAIL read_single_pulse: got acks %0d/%0d active %b want 1/0 0", ack_cnt0, ack_cnt1, bus.active);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, br, bh;
    logic w;
    logic [AW-1:0] ea;
    logic [WW-1:0] ed, word;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    pulse_reset();
    a0 = ack_cnt0;
    a1 = ack_cnt1;
    set_cmd(1'b0, 16'h0100, 1'b0, 16'h1111);
    set_cmd(1'b1, 16'h0200, 1'b0, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      w = expected_winner(1'b1, 1'b1, last_grant);
      ea = w ? 16'h0200 : 16'h0100;
      ed = w ? 16'h2222 : 16'h1111;
      @(negedge clk);
      checks++;
      if ({bus.mem_request, bus.grant} !== {1'b1, w}) begin
        errors++; $display("FAIL b2b_grant[%0d]: got req %b grant %b want 1 %b", k, bus.mem_request, bus.grant, w);
      end
      last_grant = w;
      word = 16'($urandom);
      serve(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), word, ea, 1'b0, ed, br, bh);
      checks++;
      if (br + bh !== 0) begin errors++; $display("FAIL b2b_protocol[%0d]: got req %0d hold %0d want 0 0", k, br, bh); end
      @(negedge clk);
      exp_rdata[w] = word;
      checks++;
      if ({bus.p1_ack, bus.p0_ack, bus.p0_rdata, bus.p1_rdata} !== {w, ~w, exp_rdata[0], exp_rdata[1]}) begin
        errors++; $display("FAIL b2b_ack[%0d]: got %b%b %h/%h want %b%b %h/%h", k, bus.p1_ack, bus.p0_ack,
          bus.p0_rdata, bus.p1_rdata, w, ~w, exp_rdata[0], exp_rdata[1]);
      end
      @(negedge clk);
      checks++;
      if ({bus.active, bus.p0_ack, bus.p1_ack} !== 3'b000) begin
        errors++; $display("FAIL b2b_gap[%0d]: got %b want 000", k, {bus.active, bus.p0_ack, bus.p1_ack});
      end
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    #1;
    checks++;
    if ({ack_cnt0 - a0, ack_cnt1 - a1} !== {32'd2, 32'd2}) begin
      errors++; $display("FAIL b2b_ack_count: got %0d/%0d want 2/2", ack_cnt0 - a0, ack_cnt1 - a1);
    end
  endtask

  task automatic test_write_hold();
    int br, bh;
    @(negedge clk);
    set_cmd(1'b1, 16'h0007, 1'b1, 16'hA5A5);
    @(negedge clk);
    checks++;
    if ({bus.mem_request, bus.grant, bus.mem_write_enable, bus.mem_data_out} !== {3'b111, 16'hA5A5}) begin
      errors++; $display("FAIL write_grant: got %b%b%b %h want 111 a5a5", bus.mem_request, bus.grant,
        bus.mem_write_enable, bus.mem_data_out);
    end
    last_grant   = 1'b1;
    bus.p1_wdata = 16'h0000;
    bus.p1_addr  = 16'hFFFF;
    bus.p1_we    = 1'b0;
    serve(1, 5, 16'hA5A5, 16'h0007, 1'b1, 16'hA5A5, br, bh);
    checks++;
    if (br + bh !== 0) begin errors++; $display("FAIL write_hold: got req %0d hold %0d want 0 0", br, bh); end
    @(negedge clk);
    exp_rdata[1] = 16'hA5A5;
    checks++;
    if ({bus.p1_ack, bus.mem_write_enable, bus.mem_data_out, bus.mem_address} !== {2'b11, 16'hA5A5, 16'h0007}) begin
      errors++; $display("FAIL write_done: got ack %b we %b data %h addr %h want 1 1 a5a5 0007",
        bus.p1_ack, bus.mem_write_enable, bus.mem_data_out, bus.mem_address);
    end
    checks++;
    if ({bus.p0_rdata, bus.p1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
      errors++; $display("FAIL write_rdata: got %h/%h want %h/%h", bus.p0_rdata, bus.p1_rdata, exp_rdata[0], exp_rdata[1]);
    end
    bus.p1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int a0, a1, br, bh;
    @(negedge clk);
    set_cmd(1'b0, 16'h0042, 1'b0, 16'h0000);
    @(negedge clk);
    bus.mem_busy = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_request, bus.active} !== 2'b01) begin
      errors++; $display("FAIL mid_busy: got %b want 01", {bus.mem_request, bus.active});
    end
    a0 = ack_cnt0;
    a1 = ack_cnt1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.mem_request, bus.active, bus.p0_ack, bus.p1_ack, bus.grant} !== 5'b00001) begin
      errors++; $display("FAIL mid_reset_async: got %b want 00001",
        {bus.mem_request, bus.active, bus.p0_ack, bus.p1_ack, bus.grant});
    end
    checks++;
    if ({bus.p0_rdata, bus.p1_rdata, bus.mem_address, bus.mem_data_out, bus.mem_write_enable} !== 65'h0) begin
      errors++; $display("FAIL mid_reset_regs: got %h %h %h %h %b want 0", bus.p0_rdata, bus.p1_rdata,
        bus.mem_address, bus.mem_data_out, bus.mem_write_enable);
    end
    bus.p0_req   = 1'b0;
    bus.mem_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({ack_cnt0 - a0, ack_cnt1 - a1, 31'b0, bus.active} !== 96'h0) begin
      errors++; $display("FAIL mid_no_ack: got acks %0d/%0d active %b want 0/0 0", ack_cnt0 - a0, ack_cnt1 - a1, bus.active);
    end
    set_cmd(1'b0, 16'h0043, 1'b1, 16'h1357);
    @(negedge clk);
    checks++;
    if ({bus.mem_request, bus.grant, bus.mem_address} !== {2'b10, 16'h0043}) begin
      errors++; $display("FAIL mid_recover_grant: got %b%b %h want 10 0043", bus.mem_request, bus.grant, bus.mem_address);
    end
    last_grant = 1'b0;
    serve(1, 3, 16'h1357, 16'h0043, 1'b1, 16'h1357, br, bh);
    @(negedge clk);
    exp_rdata[0] = 16'h1357;
    checks++;
    if ({br, bh, bus.p0_ack, bus.p0_rdata} !== {64'h0, 1'b1, exp_rdata[0]}) begin
      errors++; $display("FAIL mid_recover_done: got req %0d hold %0d ack %b rdata %h want 0 0 1 1357",
        br, bh, bus.p0_ack, bus.p0_rdata);
    end
    bus.p0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_delay();
    int br, bh;
    logic [WW-1:0] word;
    @(negedge clk);
    set_cmd(1'b1, 16'h0ABC, 1'b0, 16'h0F0F);
    @(negedge clk);
    checks++;
    if ({bus.mem_request, bus.grant} !== 2'b11) begin
      errors++; $display("FAIL delay_grant: got %b want 11", {bus.mem_request, bus.grant});
    end
    last_grant = 1'b1;
    bus.p1_req = 1'b0;
    word = 16'($urandom);
    serve(7, 2, word, 16'h0ABC, 1'b0, 16'h0F0F, br, bh);
    checks++;
    if (br + bh !== 0) begin errors++; $display("FAIL delay_request_hold: got req %0d hold %0d want 0 0", br, bh); end
    @(negedge clk);
    exp_rdata[1] = word;
    checks++;
    if ({bus.p1_ack, bus.p0_ack, bus.p1_rdata} !== {2'b10, exp_rdata[1]}) begin
      errors++; $display("FAIL delay_withdrawn_ack: got %b%b %h want 10 %h", bus.p1_ack, bus.p0_ack, bus.p1_rdata, exp_rdata[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic          pend [2];
    logic [AW-1:0] ca [2];
    logic          cw [2];
    logic [WW-1:0] cd [2];
    logic [WW-1:0] word;
    logic          w;
    int            br, bh;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    @(negedge clk);
    for (int it = 0; it < 40; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && ($urandom_range(0, 2) != 0 || (n == 1 && !pend[0]))) begin
          ca[n] = 16'($urandom); cw[n] = 1'($urandom_range(0, 1)); cd[n] = 16'($urandom);
          set_cmd(n[0], ca[n], cw[n], cd[n]);
          pend[n] = 1'b1;
        end
      end
      w = expected_winner(pend[0], pend[1], last_grant);
      @(negedge clk);
      checks++;
      if ({bus.mem_request, bus.grant, bus.mem_address, bus.mem_write_enable, bus.mem_data_out} !== {1'b1, w, ca[w], cw[w], cd[w]}) begin
        errors++; $display("FAIL rand_grant[%0d]: got %b %b %h %b %h want 1 %b %h %b %h", it, bus.mem_request,
          bus.grant, bus.mem_address, bus.mem_write_enable, bus.mem_data_out, w, ca[w], cw[w], cd[w]);
      end
      last_grant = w;
      if (w) begin
        if ($urandom_range(0, 1) == 1) bus.p1_req = 1'b0;
        bus.p1_addr = 16'($urandom); bus.p1_wdata = 16'($urandom); bus.p1_we = ~cw[1];
      end else begin
        if ($urandom_range(0, 1) == 1) bus.p0_req = 1'b0;
        bus.p0_addr = 16'($urandom); bus.p0_wdata = 16'($urandom); bus.p0_we = ~cw[0];
      end
      word = cw[w] ? cd[w] : 16'($urandom);
      serve(int'($urandom_range(0, 4)), int'($urandom_range(1, 5)), word, ca[w], cw[w], cd[w], br, bh);
      checks++;
      if (br + bh !== 0) begin errors++; $display("FAIL rand_protocol[%0d]: got req %0d hold %0d want 0 0", it, br, bh); end
      @(negedge clk);
      exp_rdata[w] = word;
      checks++;
      if ({bus.p1_ack, bus.p0_ack, bus.p0_rdata, bus.p1_rdata} !== {w, ~w, exp_rdata[0], exp_rdata[1]}) begin
        errors++; $display("FAIL rand_done[%0d]: got %b%b %h/%h want %b%b %h/%h", it, bus.p1_ack, bus.p0_ack,
          bus.p0_rdata, bus.p1_rdata, w, ~w, exp_rdata[0], exp_rdata[1]);
      end
      pend[w] = 1'b0;
      if (w) bus.p1_req = 1'b0;
      else bus.p0_req = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.active !== 1'b0) begin errors++; $display("FAIL rand_idle_gap[%0d]: got %b want 0", it, bus.active); end
    end
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
  endtask

  task automatic test_invariants();
    @(negedge clk);
    #1;
    checks++;
    if (both_ack_cnt !== 0) begin errors++; $display("FAIL both_acks: got %0d cycles want 0", both_ack_cnt); end
    checks++;
    if (req_outside_cnt !== 0) begin errors++; $display("FAIL request_while_idle: got %0d cycles want 0", req_outside_cnt); end
  endtask

  initial begin
    reset               = 1'b1;
    bus.p0_req          = 1'b0;
    bus.p1_req          = 1'b0;
    bus.p0_addr         = '0;
    bus.p1_addr         = '0;
    bus.p0_we           = 1'b0;
    bus.p1_we           = 1'b0;
    bus.p0_wdata        = '0;
    bus.p1_wdata        = '0;
    bus.mem_initialized = 1'b0;
    bus.mem_busy        = 1'b0;
    bus.mem_data_in     = '0;
    model_reset();
    test_reset();
    test_uninit_read();
    test_back_to_back();
    test_write_hold();
    test_reset_mid();
    test_req_delay();
    test_random();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
